// File: rtl/tbuf_bus_arbiter.sv
// Round-robin arbiter and break-before-make enable sequencer for a shared TBUFX2
// tristate bus; one driver group per requester, with a bounded ownership length.
module tbuf_bus_arbiter #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned TURN    = 1,
   parameter int unsigned MAXHOLD = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req,
   output logic [NREQ-1:0]         grant,
   output logic [NREQ-1:0]         en,
   output logic [$clog2(NREQ)-1:0] owner,
   output logic                    busy,
   output logic                    preempt
);

   localparam int unsigned IdxW     = $clog2(NREQ);
   localparam logic [3:0]  TurnInit = 4'(TURN);
   localparam logic [7:0]  HoldMax  = 8'(MAXHOLD);

   typedef enum logic [1:0] {StIdle, StDrive, StTurn} state_e;

   state_e              state_q, state_d;
   logic [NREQ-1:0]     grant_q, grant_d;
   logic [IdxW-1:0]     owner_q, owner_d;
   logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [7:0]          hold_q, hold_d;
   logic [3:0]          turn_q, turn_d;
   logic                busy_q, busy_d;
   logic                preempt_q, preempt_d;
   logic [IdxW-1:0]     win_idx;
   logic                win_valid;
   logic                do_arb;

   function automatic logic [IdxW-1:0] wrap_idx(input logic [IdxW-1:0] base,
                                                input int unsigned     off);
      int unsigned sum;
      sum = 32'(base) + off;
      return IdxW'(sum % NREQ);
   endfunction

   // Scan from the far end back toward rr_ptr so the last hit is the first set bit.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (req[wrap_idx(rr_ptr_q, NREQ - 1 - k)]) begin
            win_valid = 1'b1;
            win_idx   = wrap_idx(rr_ptr_q, NREQ - 1 - k);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      owner_d   = owner_q;
      rr_ptr_d  = rr_ptr_q;
      hold_d    = hold_q;
      turn_d    = turn_q;
      preempt_d = 1'b0;
      do_arb    = 1'b0;

      case (state_q)
         StIdle: do_arb = 1'b1;
         StDrive: begin
            if (!req[owner_q] || hold_q == HoldMax) begin
               state_d   = StTurn;
               grant_d   = '0;
               turn_d    = TurnInit;
               rr_ptr_d  = wrap_idx(owner_q, 1);
               preempt_d = req[owner_q];
            end else begin
               hold_d = hold_q + 8'd1;
            end
         end
         StTurn: begin
            if (turn_q != 4'd0) begin
               turn_d = turn_q - 4'd1;
            end
            if (turn_q <= 4'd1) begin
               do_arb = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (do_arb) begin
         if (win_valid) begin
            state_d          = StDrive;
            grant_d          = '0;
            grant_d[win_idx] = 1'b1;
            owner_d          = win_idx;
            hold_d           = 8'd1;
         end else begin
            state_d = StIdle;
         end
      end

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         grant_q   <= '0;
         owner_q   <= '0;
         rr_ptr_q  <= '0;
         hold_q    <= '0;
         turn_q    <= '0;
         busy_q    <= 1'b0;
         preempt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         owner_q   <= owner_d;
         rr_ptr_q  <= rr_ptr_d;
         hold_q    <= hold_d;
         turn_q    <= turn_d;
         busy_q    <= busy_d;
         preempt_q <= preempt_d;
      end
   end

   // en and grant share one flop bank so they can never disagree.
   assign grant   = grant_q;
   assign en      = grant_q;
   assign owner   = owner_q;
   assign busy    = busy_q;
   assign preempt = preempt_q;

endmodule

// File: tb/tb_tbuf_bus_arbiter.sv
// Directed-vector and invariant bench for tbuf_bus_arbiter across three
// TURN/MAXHOLD configurations sharing one request bus.
module tb_tbuf_bus_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = 4'b0000;

   logic [3:0] en_a, grant_a, en_r, grant_r, en_t, grant_t;
   logic [1:0] owner_a, owner_r, owner_t;
   logic       busy_a, busy_r, busy_t, pre_a, pre_r, pre_t;
   logic [3:0] prev_a = '0, prev_r = '0, prev_t = '0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   tbuf_bus_arbiter #(.NREQ(4), .TURN(1), .MAXHOLD(16)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .grant(grant_a), .en(en_a),
      .owner(owner_a), .busy(busy_a), .preempt(pre_a));

   tbuf_bus_arbiter #(.NREQ(4), .TURN(1), .MAXHOLD(2)) dut_r (
      .clk(clk), .rst_n(rst_n), .req(req), .grant(grant_r), .en(en_r),
      .owner(owner_r), .busy(busy_r), .preempt(pre_r));

   tbuf_bus_arbiter #(.NREQ(4), .TURN(3), .MAXHOLD(16)) dut_t (
      .clk(clk), .rst_n(rst_n), .req(req), .grant(grant_t), .en(en_t),
      .owner(owner_t), .busy(busy_t), .preempt(pre_t));

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic inv_ok(input logic [3:0] e, input logic [3:0] g,
                                   input logic [3:0] p);
      return $onehot0(e) && (e == g) && !(p != 4'b0 && e != 4'b0 && e != p);
   endfunction

   // Continuous invariants on every instance.
   always @(negedge clk) begin
      check("inv_a", 32'(inv_ok(en_a, grant_a, prev_a)), 32'd1);
      check("inv_r", 32'(inv_ok(en_r, grant_r, prev_r)), 32'd1);
      check("inv_t", 32'(inv_ok(en_t, grant_t, prev_t)), 32'd1);
      prev_a <= en_a;
      prev_r <= en_r;
      prev_t <= en_t;
   end

   typedef struct {
      logic [3:0] req;
      logic [3:0] en;
      logic [1:0] owner;
      logic       busy;
      logic       pre;
   } vec_t;

   vec_t vecs [19];

   task automatic do_reset();
      @(negedge clk);
      req   = 4'b0000;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      vecs[0]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
      vecs[1]  = '{4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
      vecs[2]  = '{4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
      vecs[3]  = '{4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
      vecs[4]  = '{4'b0000, 4'b0000, 2'd1, 1'b1, 1'b0};
      vecs[5]  = '{4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0};
      vecs[6]  = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
      vecs[7]  = '{4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0};
      vecs[8]  = '{4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0};
      vecs[9]  = '{4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0};
      vecs[10] = '{4'b0001, 4'b0000, 2'd3, 1'b1, 1'b0};
      vecs[11] = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
      vecs[12] = '{4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0};
      vecs[13] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
      vecs[14] = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
      vecs[15] = '{4'b0010, 4'b0000, 2'd2, 1'b1, 1'b0};
      vecs[16] = '{4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
      vecs[17] = '{4'b0000, 4'b0000, 2'd1, 1'b1, 1'b0};
      vecs[18] = '{4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0};

      // Reset values while reset is held.
      repeat (2) @(posedge clk);
      #1;
      check("rst_en", 32'(en_a), 32'd0);
      check("rst_grant", 32'(grant_a), 32'd0);
      check("rst_owner", 32'(owner_a), 32'd0);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_preempt", 32'(pre_a), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single requester, skip logic, simultaneous drop/arrive.
      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         req = vecs[i].req;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_en", i), 32'(en_a), 32'(vecs[i].en));
         check($sformatf("vec%0d_grant", i), 32'(grant_a), 32'(vecs[i].en));
         check($sformatf("vec%0d_owner", i), 32'(owner_a), 32'(vecs[i].owner));
         check($sformatf("vec%0d_busy", i), 32'(busy_a), 32'(vecs[i].busy));
         check($sformatf("vec%0d_preempt", i), 32'(pre_a), 32'(vecs[i].pre));
      end

      // Glitch: a req pulse that falls before any edge is never granted.
      @(negedge clk);
      req = 4'b0100;
      #2 req = 4'b0000;
      @(posedge clk);
      #1;
      check("glitch_en", 32'(en_a), 32'd0);
      check("glitch_busy", 32'(busy_a), 32'd0);

      // Asynchronous reset during DRIVE releases the bus without a clock edge.
      @(negedge clk);
      req = 4'b0010;
      @(posedge clk);
      #1;
      check("arst_pre_en", 32'(en_a), 32'b0010);
      #2 rst_n = 1'b0;
      #1;
      check("arst_en", 32'(en_a), 32'd0);
      check("arst_grant", 32'(grant_a), 32'd0);
      @(negedge clk);
      req   = 4'b0000;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("arst_busy", 32'(busy_a), 32'd0);
      check("arst_idle_en", 32'(en_a), 32'd0);

      // Rotation with MAXHOLD=2: owners 0,1,2,3,0, each 2 cycles, one gap, preempt.
      do_reset();
      @(negedge clk);
      req = 4'b1111;
      for (int c = 0; c < 14; c++) begin
         logic [3:0] exp_en;
         int ph;
         int idx;
         ph  = c % 3;
         idx = (c / 3) % 4;
         exp_en = (ph < 2) ? 4'(1 << idx) : 4'b0000;
         @(posedge clk);
         #1;
         check($sformatf("rot%0d_en", c), 32'(en_r), 32'(exp_en));
         check($sformatf("rot%0d_preempt", c), 32'(pre_r), (ph == 2) ? 32'd1 : 32'd0);
         check($sformatf("rot%0d_owner", c), 32'(owner_r), 32'(idx));
      end

      // TURN=3: owner drops while another requests -> 3 dead cycles.
      do_reset();
      @(negedge clk);
      req = 4'b0001;
      @(posedge clk);
      #1;
      check("turn_first_en", 32'(en_t), 32'b0001);
      @(negedge clk);
      req = 4'b0010;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         #1;
         check($sformatf("turn%0d_en", c), 32'(en_t), (c == 3) ? 32'b0010 : 32'd0);
         check($sformatf("turn%0d_busy", c), 32'(busy_t), 32'd1);
      end
      check("turn_owner", 32'(owner_t), 32'd1);

      // Random run; invariants are checked every cycle by the monitor.
      do_reset();
      for (int c = 0; c < 10000; c++) begin
         @(negedge clk);
         req = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      req = 4'b0000;
      repeat (5) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
